// File: rtl/prbs_ber_checker.sv
// PRBS9 bit-error-rate checker: slices one sample per symbol at a selectable phase,
// self-synchronises a local PRBS9 (x^9+x^5+1) and counts checked bits and errors.
module prbs_ber_checker #(
    parameter int NB_DATA  = 13,
    parameter int NB_PHASE = 3,
    parameter int NB_CNT   = 32,
    parameter int NB_WIN   = 7,
    parameter int ERR_THR  = 8
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_valid,
    input  logic [NB_DATA-1:0]  i_data,
    input  logic [NB_PHASE-1:0] i_phase,
    input  logic                i_clear,
    output logic                o_rx_bit,
    output logic                o_rx_valid,
    output logic                o_lock,
    output logic [NB_CNT-1:0]   o_bit_count,
    output logic [NB_CNT-1:0]   o_err_count,
    output logic                o_dbg_state
);

    typedef enum logic {ST_LOAD = 1'b0, ST_CHECK = 1'b1} state_t;

    localparam logic [NB_WIN:0] THR = (NB_WIN + 1)'(ERR_THR);

    state_t              state_q;
    logic [NB_PHASE-1:0] ph_q, ph_d, cur_ph;
    logic                rx_bit_q, rx_valid_q;
    logic [8:0]          s_q, s_load;
    logic [3:0]          load_cnt_q;
    logic [NB_WIN-1:0]   win_cnt_q;
    logic [NB_WIN:0]     win_err_q, win_err_d;
    logic                lock_q;
    logic [NB_CNT-1:0]   bit_cnt_q, err_cnt_q, bit_cnt_d, err_cnt_d;
    logic                decide, step, pred, err, data_nonneg;

    always_comb begin
        cur_ph      = i_valid ? '0 : ph_q;
        ph_d        = i_valid ? NB_PHASE'(1) : ph_q + NB_PHASE'(1);
        decide      = (cur_ph == i_phase);
        data_nonneg = ($signed(i_data) >= 0);
        step        = i_enable & rx_valid_q;
        pred        = s_q[8] ^ s_q[4];
        err         = pred ^ rx_bit_q;
        s_load      = {s_q[7:0], rx_bit_q};
        win_err_d   = win_err_q + (NB_WIN + 1)'(err);
        bit_cnt_d   = (&bit_cnt_q) ? bit_cnt_q : bit_cnt_q + NB_CNT'(1);
        err_cnt_d   = ((&err_cnt_q) || !err) ? err_cnt_q : err_cnt_q + NB_CNT'(1);
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            state_q    <= ST_LOAD;
            ph_q       <= '0;
            rx_bit_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            s_q        <= 9'h1FF;
            load_cnt_q <= '0;
            win_cnt_q  <= '0;
            win_err_q  <= '0;
            lock_q     <= 1'b0;
            bit_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else if (i_enable) begin
            ph_q       <= ph_d;
            rx_valid_q <= decide;
            if (decide) rx_bit_q <= data_nonneg;

            if (i_clear) begin
                bit_cnt_q <= '0;
                err_cnt_q <= '0;
            end else if (step && state_q == ST_CHECK) begin
                bit_cnt_q <= bit_cnt_d;
                err_cnt_q <= err_cnt_d;
            end

            if (step) begin
                case (state_q)
                    ST_LOAD: begin
                        s_q <= s_load;
                        if (load_cnt_q == 4'd8) begin
                            load_cnt_q <= '0;
                            win_cnt_q  <= '0;
                            win_err_q  <= '0;
                            // An all-zero seed would lock the generator at zero forever.
                            state_q    <= (s_load == 9'h000) ? ST_LOAD : ST_CHECK;
                        end else begin
                            load_cnt_q <= load_cnt_q + 4'd1;
                        end
                    end
                    ST_CHECK: begin
                        s_q       <= {s_q[7:0], pred};
                        win_cnt_q <= win_cnt_q + NB_WIN'(1);
                        if (win_cnt_q == '1) begin
                            win_err_q <= '0;
                            if (win_err_d > THR) begin
                                lock_q     <= 1'b0;
                                state_q    <= ST_LOAD;
                                load_cnt_q <= '0;
                            end else begin
                                lock_q <= 1'b1;
                            end
                        end else begin
                            win_err_q <= win_err_d;
                        end
                    end
                    default: state_q <= ST_LOAD;
                endcase
            end
        end
    end

    // A decision held across a disabled stretch is still processed once on resume.
    assign o_rx_valid  = rx_valid_q & i_enable;
    assign o_rx_bit    = rx_bit_q;
    assign o_lock      = lock_q;
    assign o_bit_count = bit_cnt_q;
    assign o_err_count = err_cnt_q;
    assign o_dbg_state = state_q;

endmodule
